// File: rtl/digit_serial_adder_if.sv
// Handshake and operand/result bundle for digit_serial_adder.
// master drives requests and operands; slave returns status and result.
interface digit_serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, carry, overflow
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, carry, overflow
    );
endinterface

// File: rtl/digit_serial_adder.sv
// Digit-serial two's-complement add/subtract, DIGIT bits per clock, LSB first.
// Define SUB_EN to honour the sub input; otherwise sub is ignored (add only).
module digit_serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input logic               clk,
    input logic               rst,
    digit_serial_adder_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_osum;
    logic             r_ocarry;
    logic             r_ovf;

    logic [DIGIT-1:0] w_dig;
    logic             w_cy;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_sum_nx;
    logic [WIDTH-1:0] w_bin;
    logic             w_cin;
    logic             w_accept;
    logic             w_last;

`ifdef SUB_EN
    // subtract as a + ~b + ~borrow_in
    assign w_bin = bus.sub ? ~bus.b : bus.b;
    assign w_cin = bus.cin ^ bus.sub;
`else
    assign w_bin = bus.b;
    assign w_cin = bus.cin;
`endif

    assign w_accept = bus.start &&
                      (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_cnt == CW'(NDIG - 1));

    always_comb begin
        w_dig  = '0;
        w_cmsb = 1'b0;
        w_cy   = r_c;
        for (int i = 0; i < DIGIT; i++) begin
            w_dig[i] = r_a[i] ^ r_b[i] ^ w_cy;
            if (i == DIGIT - 1)
                w_cmsb = w_cy;
            w_cy = (r_a[i] & r_b[i]) |
                   (w_cy & (r_a[i] ^ r_b[i]));
        end
    end

    // new digit enters from the MSB side; after NDIG shifts it is aligned
    assign w_sum_nx = (WIDTH'(w_dig) << (WIDTH - DIGIT)) |
                      (r_sum >> DIGIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_osum   <= '0;
            r_ocarry <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_state <= RUN;
            r_a     <= bus.a;
            r_b     <= w_bin;
            r_c     <= w_cin;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                RUN: begin
                    r_a   <= r_a >> DIGIT;
                    r_b   <= r_b >> DIGIT;
                    r_c   <= w_cy;
                    r_sum <= w_sum_nx;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state  <= DONE;
                        r_cnt    <= '0;
                        r_osum   <= w_sum_nx;
                        r_ocarry <= w_cy;
                        r_ovf    <= w_cmsb ^ w_cy;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (r_state == RUN);
    assign bus.done     = (r_state == DONE);
    assign bus.sum      = r_osum;
    assign bus.carry    = r_ocarry;
    assign bus.overflow = r_ovf;
endmodule
